// File: rtl/transparency_fade_controller.sv
// transparency_fade_controller
// Ramps proportion_out one LSB per N frame boundaries toward a commanded target,
// so that a frame is never rendered with two different blend proportions.
// Optional feature: define TRANSPARENCY_FADE_SNAP_EN to add the cmd_snap input,
// which makes a command jump straight to its target on the first frame boundary.
//
// Command handshake: a command is accepted on a rising clk edge where
// cmd_valid && cmd_ready; cmd_ready is high only in IDLE, and cmd_valid is
// ignored at all other times.
module transparency_fade_controller #(
  parameter int TRANSPARENCY_PRECISION = 3,
  parameter int INTERVAL_WIDTH         = 8,
  parameter int RESET_PROPORTION       = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              frame_start,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [TRANSPARENCY_PRECISION-1:0] cmd_target,
  input  logic [INTERVAL_WIDTH-1:0]         cmd_interval,
`ifdef TRANSPARENCY_FADE_SNAP_EN
  input  logic                              cmd_snap,
`endif
  input  logic                              abort,
  output logic [TRANSPARENCY_PRECISION-1:0] proportion_out,
  output logic                              busy,
  output logic                              done
);

  localparam int P = TRANSPARENCY_PRECISION;
  localparam logic [P-1:0] RESET_VAL = RESET_PROPORTION[P-1:0];
  localparam logic [INTERVAL_WIDTH-1:0] ONE = {{(INTERVAL_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, FADE = 2'd1, DONE = 2'd2} state_t;

  // state is the FSM register; kept under this name for hierarchical probing
  state_t                    state, state_n;
  logic [P-1:0]              prop_q, prop_n;
  logic [P-1:0]              target_q, target_n;
  logic [INTERVAL_WIDTH-1:0] interval_q, interval_n;
  logic [INTERVAL_WIDTH-1:0] frame_cnt, frame_cnt_n;
  logic                      snap_q, snap_n;
  logic [P-1:0]              step_val;

  // value one LSB closer to the target; never leaves the legal range
  always_comb begin
    step_val = prop_q;
    if (target_q > prop_q)      step_val = prop_q + 1'b1;
    else if (target_q < prop_q) step_val = prop_q - 1'b1;
  end

  // next-state, next-value and output decode
  always_comb begin
    state_n     = state;
    prop_n      = prop_q;
    target_n    = target_q;
    interval_n  = interval_q;
    frame_cnt_n = frame_cnt;
    snap_n      = snap_q;
    cmd_ready   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          target_n    = cmd_target;
          interval_n  = (cmd_interval == '0) ? ONE : cmd_interval;
          frame_cnt_n = '0;
`ifdef TRANSPARENCY_FADE_SNAP_EN
          snap_n      = cmd_snap;
`else
          snap_n      = 1'b0;
`endif
          state_n     = (cmd_target == prop_q) ? DONE : FADE;
        end
      end
      FADE: begin
        busy = 1'b1;
        if (abort) begin
          // freeze where we are; abort wins over a coincident frame boundary
          state_n = IDLE;
        end else if (frame_start) begin
          if (snap_q) begin
            prop_n  = target_q;
            state_n = DONE;
          end else if (frame_cnt == interval_q - ONE) begin
            prop_n      = step_val;
            frame_cnt_n = '0;
            if (step_val == target_q) state_n = DONE;
          end else begin
            frame_cnt_n = frame_cnt + ONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // state and datapath registers, asynchronously reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      prop_q     <= RESET_VAL;
      target_q   <= RESET_VAL;
      interval_q <= ONE;
      frame_cnt  <= '0;
      snap_q     <= 1'b0;
    end else begin
      state      <= state_n;
      prop_q     <= prop_n;
      target_q   <= target_n;
      interval_q <= interval_n;
      frame_cnt  <= frame_cnt_n;
      snap_q     <= snap_n;
    end
  end

  assign proportion_out = prop_q;

endmodule
